// File: rtl/draw_pkg.sv
// Shared definitions for the draw-buffer address generators (reader and writer).
package draw_pkg;

  localparam int unsigned DRAW_ADDR_W    = 14;
  localparam int unsigned DRAW_DATA_W    = 8;
  localparam int unsigned DRAW_BASE_PAIR = 6400;
  localparam int unsigned DRAW_NUM_PAIRS = 129;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND_A  = 3'd3,
    ST_SEND_B  = 3'd4
  } pair_rd_state_t;

endpackage

// File: rtl/pair_reader.sv
// pair_reader: walks a window of word pairs in the dual-port draw RAM, one
// read per pair, and serializes each pair as two bytes on a valid/ready stream.
// Optional macro PAIR_READER_SWAP_EN sends the odd word of each pair first.
module pair_reader
  import draw_pkg::*;
#(
  parameter int unsigned ADDR_W    = DRAW_ADDR_W,
  parameter int unsigned DATA_W    = DRAW_DATA_W,
  parameter int unsigned BASE_PAIR = DRAW_BASE_PAIR,
  parameter int unsigned NUM_PAIRS = DRAW_NUM_PAIRS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] rdata_a,
  input  logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PAIR_W = ADDR_W - 1;
  localparam logic [PAIR_W-1:0] BASE_IDX = PAIR_W'(BASE_PAIR);
  localparam logic [PAIR_W-1:0] LAST_IDX = PAIR_W'(BASE_PAIR + NUM_PAIRS - 1);

  pair_rd_state_t    state_q, state_d;
  logic [PAIR_W-1:0] pair_q, pair_d;
  logic [DATA_W-1:0] hold_a_q, hold_a_d;
  logic [DATA_W-1:0] hold_b_q, hold_b_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] first_word_c, second_word_c;

  // State and output registers; outputs are precomputed from the next state
  // so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pair_q      <= '0;
      hold_a_q    <= '0;
      hold_b_q    <= '0;
      rd_en_q     <= 1'b0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pair_q      <= pair_d;
      hold_a_q    <= hold_a_d;
      hold_b_q    <= hold_b_d;
      rd_en_q     <= rd_en_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic and next values of the registered outputs.
  always_comb begin
    state_d       = state_q;
    pair_d        = pair_q;
    hold_a_d      = hold_a_q;
    hold_b_d      = hold_b_q;
    done_d        = 1'b0;
    first_word_c  = '0;
    second_word_c = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          pair_d  = BASE_IDX;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        hold_a_d = rdata_a;
        hold_b_d = rdata_b;
        state_d  = ST_SEND_A;
      end
      ST_SEND_A: begin
        if (out_ready) begin
          state_d = ST_SEND_B;
        end
      end
      ST_SEND_B: begin
        if (out_ready) begin
          if (pair_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            pair_d  = pair_q + PAIR_W'(1);
            state_d = ST_FETCH;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef PAIR_READER_SWAP_EN
    first_word_c  = hold_b_d;
    second_word_c = hold_a_d;
`else
    first_word_c  = hold_a_d;
    second_word_c = hold_b_d;
`endif

    rd_en_d     = (state_d == ST_FETCH);
    addr_a_d    = rd_en_d ? {pair_d, 1'b0} : addr_a_q;
    addr_b_d    = rd_en_d ? {pair_d, 1'b1} : addr_b_q;
    out_valid_d = (state_d == ST_SEND_A) || (state_d == ST_SEND_B);
    out_last_d  = (state_d == ST_SEND_B) && (pair_d == LAST_IDX);
    busy_d      = (state_d != ST_IDLE);
    if (state_d == ST_SEND_A) begin
      out_data_d = first_word_c;
    end else if (state_d == ST_SEND_B) begin
      out_data_d = second_word_c;
    end else begin
      out_data_d = '0;
    end
  end

  assign rd_en     = rd_en_q;
  assign addr_a    = addr_a_q;
  assign addr_b    = addr_b_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/pair_reader.md
# pair_reader

Read-side address generator and serializer for the draw-buffer dual-port RAM. On `start`, it walks a window of word pairs. Each pair is an even word on port A and an odd word on port B. The block issues one synchronous read per pair, captures both words, and emits them as a valid/ready byte stream (even word first, then odd word). It sits between the dual-port draw memory and the downstream display/UART consumer. It is the counterpart of the pair-address writer that fills that memory.

## Interface
Parameters:
- `ADDR_W`, 14: RAM word address width; pair index width is `ADDR_W-1`.
- `DATA_W`, 8: RAM word and stream width.
- `BASE_PAIR`, 6400: first pair index read.
- `NUM_PAIRS`, 129: pairs per frame; must be ≥1 and `BASE_PAIR+NUM_PAIRS ≤ 2**(ADDR_W-1)`.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `start`, in, 1: one-cycle request to read a frame; honoured only in IDLE.
- `rd_en`, out, 1: RAM read enable (both ports).
- `addr_a`, out, `ADDR_W`: port A address, `{pair, 1'b0}`.
- `addr_b`, out, `ADDR_W`: port B address, `{pair, 1'b1}`.
- `rdata_a`, in, `DATA_W`: port A read data, valid one cycle after `rd_en`.
- `rdata_b`, in, `DATA_W`: port B read data, same latency.
- `out_data`, out, `DATA_W`: stream data.
- `out_valid`, out, 1: stream data valid.
- `out_ready`, in, 1: downstream accept.
- `out_last`, out, 1: marks the final word of the frame.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse after the last word is accepted.

## Operation
- FSM states: IDLE, FETCH, CAPTURE, SEND_A, SEND_B.
- IDLE: outputs inactive. `start=1` loads `pair<=BASE_PAIR` and moves to FETCH.
- FETCH: `rd_en=1`, addresses driven from `pair`. Moves to CAPTURE unconditionally.
- CAPTURE: latches `rdata_a` into `hold_a` and `rdata_b` into `hold_b`. Moves to SEND_A.
- SEND_A: `out_valid=1`, `out_data=hold_a`. On `out_ready`, moves to SEND_B.
- SEND_B: `out_valid=1`, `out_data=hold_b`, `out_last=(pair==BASE_PAIR+NUM_PAIRS-1)`.
  - On `out_ready` with `out_last`: `done` pulses next cycle and the FSM goes to IDLE.
  - On `out_ready` otherwise: `pair<=pair+1` and the FSM goes to FETCH.
- Handshake: a transfer occurs when `out_valid & out_ready` are high on a rising edge. `out_data` and `out_last` are held stable while `out_valid=1` and `out_ready=0`.
- `start` while busy is ignored, with no queuing.
- `pair` arithmetic is `ADDR_W-1` bits, with no wrap inside a legal window.
- `addr_a` and `addr_b` are registered, and hold their last value outside FETCH.

## Timing
- Reset values: `rd_en=0`, `addr_a=0`, `addr_b=0`, `out_data=0`, `out_valid=0`, `out_last=0`, `busy=0`, `done=0`, state IDLE, `pair=0`, hold registers 0.
- Latency with `out_ready` tied high:
  - `start` sampled at edge 0.
  - `rd_en` is high in cycle 1.
  - Capture occurs in cycle 2.
  - The first `out_valid` is in cycle 3.
  - Each pair takes 4 cycles, so a frame takes `4*NUM_PAIRS` cycles.
  - `done` is high in the cycle after the final transfer.
- Back-pressure only stretches SEND_A and SEND_B; FETCH and CAPTURE are never stalled.
- Reset asserted mid-frame: the block returns to IDLE immediately. No `done`, no `out_last`, and any partially sent pair is dropped.
- `done` and `start` in the same cycle: `start` is accepted, because the state is already IDLE when `done` is high.

## Configuration
- `PAIR_READER_SWAP_EN`:
  - When defined, SEND_A outputs `hold_b` and SEND_B outputs `hold_a`, so the odd word goes first. `out_last` still marks the second word of the final pair.
  - When undefined, the order is even word first, as described above.
- Addresses and timing are unchanged in both cases.

## Structure
- Shared package `draw_pkg`:
  - FSM state enum `pair_rd_state_t`.
  - Default constants `DRAW_BASE_PAIR=6400`, `DRAW_NUM_PAIRS=129`, `DRAW_ADDR_W=14`.
  - These are shared with the writer-side address generator.
- No sub-module is required. The stream output register stage may be split out as `stream_out_reg` if reused by other draw blocks.

## Test plan
- Reset, then `start` with `out_ready=1` and RAM preloaded `mem[k]=k[7:0]`:
  - Addresses go 12800/12801 … 13056/13057.
  - The stream is 0x00,0x01,…,0x01 (wrapping low byte), 258 words.
  - `out_last` is set only on word 258.
  - `done` fires at cycle 517.
- Random `out_ready` (50% duty):
  - The same 258 words arrive in order with no duplication or loss.
  - `out_data` stays stable while stalled.
- `start` pulsed again mid-frame, at pair 6410: ignored, and the frame completes normally.
- `reset` asserted while in SEND_B of pair 6450: all outputs return to reset values in the same cycle, and no `done` is produced. A subsequent `start` restarts at 12800.
- `NUM_PAIRS=1`, `BASE_PAIR=0`: exactly 2 words are output, `out_last` is on the second, and `done` fires at cycle 5.
- `PAIR_READER_SWAP_EN` defined: the first two words are `mem[12801]` then `mem[12800]`, and `out_last` is on `mem[13056]`.
